// File: rtl/imem_program_writer.sv
// imem_program_writer: packs decoded RV32I fields into instruction words and
// streams them into instruction memory, one word per accepted beat.
module imem_program_writer #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            fmt,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [31:0]           imm,
    input  logic                  done,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  err
);

    localparam logic [DEPTH_LOG2:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {StLoad, StDone} state_t;

    state_t                r_state;
    state_t                w_state_d;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_d;
    logic [31:0]           r_wr_ptr;
    logic [31:0]           w_wr_ptr_d;
    logic                  r_mem_we;
    logic                  w_mem_we_d;
    logic [31:0]           r_mem_addr;
    logic [31:0]           w_mem_addr_d;
    logic [31:0]           r_mem_wdata;
    logic [31:0]           w_mem_wdata_d;
    logic                  r_err;
    logic                  w_err_d;

    logic                  w_full;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_illegal;
    logic [31:0]           w_enc;

    // Capacity is exhausted once count hits 2**DEPTH_LOG2; count never exceeds it.
    assign w_full   = (r_count == CAP);
    // Ready comes only from flopped state, so it never loops back through in_valid.
    assign w_ready  = (r_state == StLoad) && !w_full;
    assign w_accept = in_valid && w_ready;

    // Illegal format, non-32-bit opcode, or odd branch/jump offset.
    assign w_illegal = (fmt > 3'd5) || (opcode[1:0] != 2'b11) ||
                       (((fmt == 3'd3) || (fmt == 3'd5)) && imm[0]);

    // Instruction word assembly for each format class.
    always_comb begin
        w_enc = 32'h0;
        case (fmt)
            3'd0:    w_enc = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1:    w_enc = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2:    w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd3:    w_enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            3'd4:    w_enc = {imm[31:12], rd, opcode};
            3'd5:    w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: w_enc = 32'h0;
        endcase
    end

    // Next-state: accepted beats either write (legal) or flag err (illegal).
    always_comb begin
        w_state_d     = r_state;
        w_count_d     = r_count;
        w_wr_ptr_d    = r_wr_ptr;
        w_mem_we_d    = 1'b0;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        w_err_d       = r_err;
        if (w_accept) begin
            if (w_illegal) begin
                w_err_d = 1'b1;
            end else begin
                w_mem_we_d    = 1'b1;
                w_mem_addr_d  = r_wr_ptr;
                w_mem_wdata_d = w_enc;
                w_wr_ptr_d    = r_wr_ptr + 32'd4;
                w_count_d     = r_count + 1'b1;
            end
            if (done) begin
                w_state_d = StDone;
            end
        end
    end

    // State and output registers; reset drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StLoad;
            r_count     <= '0;
            r_wr_ptr    <= BASE_ADDR;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_count     <= w_count_d;
            r_wr_ptr    <= w_wr_ptr_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_err       <= w_err_d;
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;
    assign full      = w_full;
    assign err       = r_err;

endmodule

// File: doc/imem_program_writer.md
# imem_program_writer

Builds RV32I instruction words from decoded fields and writes them into instruction memory, one word per accepted beat. Each beat carries a format class, opcode, register fields, funct fields and a 32-bit immediate. The block sits between the bench or boot host and the instruction memory, ahead of the core's decode path. Its output words must decode back through the core's opcode-driven control path to the same fields.

## Interface
- DEPTH_LOG2, 6, log2 of program capacity in 32-bit words (64 words)
- BASE_ADDR, 32'h0, byte address of the first written word (word aligned)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat offered
- in_ready  out  1  beat can be taken; transfer when in_valid & in_ready
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6..7 are illegal
- opcode  in  7  full opcode; bits [1:0] must be 2'b11
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3; funct7  in  7
- imm  in  32  immediate, sign-extended byte offset for B/J
- done  in  1  end of program; stops further loading
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  32  byte address, increments by 4
- mem_wdata  out  32  encoded instruction
- count  out  DEPTH_LOG2+1  words written so far
- full  out  1  count == 2**DEPTH_LOG2
- err  out  1  sticky illegal-beat flag

## Operation
- Reset is asynchronous and active-high. While asserted: state=LOAD, count=0, wr_ptr=BASE_ADDR, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err=0, full=0. A write pending when reset arrives is dropped.
- State LOAD:
  - in_ready = ~full.
  - An accepted beat with done=1 moves to state DONE. The same beat is still processed.
- State DONE:
  - in_ready=0. No writes occur.
  - DONE holds until reset.
- Encoding, with fields concatenated MSB first:
  - R: funct7, rs2, rs1, funct3, rd, opcode
  - I: imm[11:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
- Fields unused by a format are ignored. Out-of-range immediates are truncated silently.
- A beat is illegal if any of the following holds:
  - fmt > 5
  - opcode[1:0] != 2'b11
  - fmt is B or J and imm[0] = 1
- Handling of an illegal beat:
  - It is still accepted: the handshake completes.
  - It is not written, and count does not change.
  - err is set and stays set until reset.
  - A done on an illegal beat still moves to DONE.
- Handling of a legal beat:
  - The encoded word is written at wr_ptr.
  - wr_ptr advances by 4 and count increments.
- full:
  - Asserts when count reaches 2**DEPTH_LOG2. in_ready then drops; full stays asserted until reset.
  - No wrap-around. The pointer never returns to BASE_ADDR without a reset.
- With done=1 and in_ready=0 (full), nothing is transferred and the state stays LOAD. done is acted on only when it arrives with an accepted beat.

## Timing
- Accept in cycle N, then in cycle N+1: mem_we=1, mem_addr=old wr_ptr, mem_wdata=encoded word.
- Latency from transfer to write is 1 cycle. Throughput is 1 word per cycle.
- mem_we is high for exactly one cycle per legal beat, with no bubbles needed.
- count and full update in cycle N+1, together with mem_we.
- in_ready is registered:
  - It depends on full and state only, never combinationally on in_valid.
  - In the last free slot, in_ready is high for the final accept. In cycle N+1 in_ready=0 and full=1.
- err rises in cycle N+1 after an illegal accept.
- mem_addr and mem_wdata hold their last values while mem_we=0.

## Test plan
- R-type, ADD x3,x1,x2: fmt=0, opcode=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> next cycle mem_we=1, mem_addr=0x0, mem_wdata=0x002081B3, count=1.
- I then S, back-to-back:
  - ADDI x1,x0,5 (0x13, imm=5) -> 0x00500093 at 0x0.
  - SW x2,8(x1) (0x23, f3=2, imm=8) -> 0x0020A423 at 0x4, on consecutive cycles.
- B/J/U:
  - BEQ x1,x2,-4 (0x63, imm=0xFFFFFFFC) -> 0xFE208EE3.
  - JAL x1,+8 (0x6F) -> 0x008000EF.
  - LUI x5 (0x37, imm=0x12345000) -> 0x123452B7.
- Illegal beats:
  - fmt=7 -> accepted, no mem_we, count unchanged, err=1.
  - A later legal beat still writes at the unchanged address; err stays 1.
  - B with imm=3 -> err, no write.
- Full: DEPTH_LOG2=2, stream 5 legal beats -> 4 writes at 0x0..0xC. Then full=1, in_ready=0, and the 5th beat is held, not accepted.
- done and reset:
  - Beat with done=1 -> written, then in_ready=0 and no further writes despite in_valid=1.
  - Assert rst in the cycle after an accept -> mem_we=0 immediately, count=0, mem_addr=BASE_ADDR.
